inst_loader: RTL and testbench

- Write-side counterpart of the instruction memory: receives a program as a byte stream and writes it word by word into instruction-memory storage.
- Holds the processor off (CpuHold) while loading, then releases it.
- Sits between a byte source (UART receiver, debug port or testbench) and the instruction-memory write port.
- The read side continues to fetch instruction words by byte address, addressed word index = address >> 2.

---
 rtl/inst_loader.sv | 173 +++++++++++++++++
 tb/tb_inst_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// inst_loader: receives a program as a byte stream and writes it word by word
// into instruction-memory storage, holding the processor off while loading.
//
// Stream format: 2-byte little-endian word count, then count*4 bytes, each
// word little-endian.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   Start        one-cycle pulse; begins a load from IDLE, DONE or ERR
//   ByteIn       stream data byte
//   ByteValid    ByteIn valid; a byte transfers when ByteValid && ByteReady
//   ByteReady    loader can accept a byte this cycle
//   MemWe        instruction-memory write enable, one pulse per word
//   MemAddr      byte address of the word being written (multiple of 4)
//   MemWdata     assembled instruction word
//   CpuHold      high while a load is in progress
//   Done         level; load completed successfully
//   Error        level; header length exceeded DEPTH_WORDS
module inst_loader #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LEN_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWdata,
    output logic        CpuHold,
    output logic        Done,
    output logic        Error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [23:0]        word_q, word_d;
    logic               byte_ready_q, byte_ready_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               accept;
    logic [15:0]        hdr_len;
    logic [LEN_W-1:0]   idx_next;

    assign accept   = ByteValid && byte_ready_q;
    assign hdr_len  = {ByteIn, len_q[7:0]};
    assign idx_next = word_idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (Start) begin
                    state_d    = S_LEN0;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_d   = LEN_W'(ByteIn);
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d = LEN_W'(hdr_len);
                    if (hdr_len == 16'd0) begin
                        state_d = S_DONE;
                    end else if (32'(hdr_len) > DEPTH_WORDS) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    case (byte_cnt_q)
                        2'd0: word_d[7:0]   = ByteIn;
                        2'd1: word_d[15:8]  = ByteIn;
                        2'd2: word_d[23:16] = ByteIn;
                        default: begin
                            // Fourth byte goes straight into the write register
                            // so the word is presented during the WRITE cycle.
                            mem_wdata_d = {ByteIn, word_q};
                            mem_addr_d  = 32'(word_idx_q) << 2;
                            state_d     = S_WRITE;
                        end
                    endcase
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end
            S_WRITE: begin
                word_idx_d = idx_next;
                state_d    = (idx_next == len_q) ? S_DONE : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered: they follow the state being entered.
        byte_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
        mem_we_d     = (state_d == S_WRITE);
        cpu_hold_d   = byte_ready_d || mem_we_d;
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign ByteReady = byte_ready_q;
    assign MemWe     = mem_we_q;
    assign MemAddr   = mem_addr_q;
    assign MemWdata  = mem_wdata_q;
    assign CpuHold   = cpu_hold_q;
    assign Done      = done_q;
    assign Error     = error_q;

endmodule

// File: tb/tb_inst_loader.sv
// Testbench for inst_loader: random programs are loaded through the byte
// stream; expected writes are queued when issued and a monitor pops and
// compares them whenever MemWe is seen.
module tb_inst_loader;

    localparam int unsigned DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  ByteIn = '0;
    logic        ByteValid = 1'b0;
    logic        ByteReady;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWdata;
    logic        CpuHold;
    logic        Done;
    logic        Error;

    inst_loader #(.DEPTH_WORDS(DEPTH), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .ByteIn(ByteIn),
        .ByteValid(ByteValid), .ByteReady(ByteReady), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemWdata(MemWdata), .CpuHold(CpuHold),
        .Done(Done), .Error(Error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    logic [31:0] last_addr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && MemWe) begin
            we_cnt++;
            last_addr = MemAddr;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                         MemAddr, MemWdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", MemAddr, mon_e.a);
                chk("wr_data", MemWdata, mon_e.d);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps, output int stall);
        logic r;
        if (gaps) begin
            ByteValid = 1'b0;
            ByteIn = 8'($urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        ByteValid = 1'b1;
        ByteIn = b;
        stall = 0;
        forever begin
            @(negedge clk);
            r = ByteReady;
            @(posedge clk);
            #1;
            if (r) break;
            stall++;
            if (stall > 40) begin
                checks++;
                errors++;
                $display("FAIL byte_timeout: got no acceptance in %0d cycles expected acceptance", stall);
                break;
            end
        end
        ByteValid = 1'b0;
    endtask

    task automatic run_load(input int unsigned len, input bit gaps, input bit start_with_byte);
        int          st;
        logic [31:0] w;
        logic [15:0] l16;
        l16 = 16'(len);
        // Optionally offer a bogus byte together with Start; it must not be consumed.
        ByteValid = start_with_byte;
        ByteIn = 8'hAA;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        ByteValid = 1'b0;
        chk("hold_after_start", {31'b0, CpuHold}, 32'd1);
        chk("done_cleared", {31'b0, Done}, 32'd0);
        chk("error_cleared", {31'b0, Error}, 32'd0);
        send_byte(l16[7:0], gaps, st);
        send_byte(l16[15:8], gaps, st);
        if (len == 0) begin
            @(negedge clk);
            chk("zero_done", {31'b0, Done}, 32'd1);
            chk("zero_hold", {31'b0, CpuHold}, 32'd0);
            return;
        end
        if (len > DEPTH) begin
            @(negedge clk);
            chk("over_error", {31'b0, Error}, 32'd1);
            chk("over_ready", {31'b0, ByteReady}, 32'd0);
            chk("over_hold", {31'b0, CpuHold}, 32'd0);
            chk("over_done", {31'b0, Done}, 32'd0);
            return;
        end
        for (int unsigned i = 0; i < len; i++) begin
            w = $urandom;
            exp_q.push_back('{a: i * 4, d: w});
            for (int unsigned k = 0; k < 4; k++) begin
                send_byte(8'((w >> (8 * k)) & 32'hFF), gaps, st);
                // Without gaps only the first byte of a later word waits, for the write cycle.
                if (!gaps && i < 4)
                    chk("stall_cycles", 32'(st), (i > 0 && k == 0) ? 32'd1 : 32'd0);
            end
        end
        @(negedge clk);
        chk("last_we", {31'b0, MemWe}, 32'd1);
        @(negedge clk);
        chk("load_done", {31'b0, Done}, 32'd1);
        chk("load_hold", {31'b0, CpuHold}, 32'd0);
        chk("load_ready", {31'b0, ByteReady}, 32'd0);
        chk("load_error", {31'b0, Error}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        int base;
        // Reset state
        #12;
        chk("rst_ready", {31'b0, ByteReady}, 32'd0);
        chk("rst_we", {31'b0, MemWe}, 32'd0);
        chk("rst_addr", MemAddr, 32'd0);
        chk("rst_wdata", MemWdata, 32'd0);
        chk("rst_flags", {29'b0, CpuHold, Done, Error}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", {31'b0, ByteReady}, 32'd0);

        // Reset mid-load
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        send_byte(8'h02, 1'b0, st);
        send_byte(8'h00, 1'b0, st);
        exp_q.push_back('{a: 32'h0, d: 32'h00100513});
        send_byte(8'h13, 1'b0, st);
        send_byte(8'h05, 1'b0, st);
        send_byte(8'h10, 1'b0, st);
        send_byte(8'h00, 1'b0, st);
        send_byte(8'hAB, 1'b0, st);
        send_byte(8'hCD, 1'b0, st);
        base = we_cnt;
        chk("first_word_written", 32'(base), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_addr", MemAddr, 32'd0);
        chk("async_rst_wdata", MemWdata, 32'd0);
        chk("async_rst_flags", {27'b0, ByteReady, MemWe, CpuHold, Done, Error}, 32'd0);
        ByteValid = 1'b1;
        ByteIn = 8'hEF;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ByteIn = 8'h01;
        repeat (8) @(posedge clk);
        #1;
        ByteValid = 1'b0;
        chk("no_we_after_rst", 32'(we_cnt), 32'(base));
        chk("idle_after_rst", {30'b0, ByteReady, CpuHold}, 32'd0);

        // Normal 3-word load, then bytes offered in DONE are ignored
        run_load(3, 1'b0, 1'b0);
        ByteValid = 1'b1;
        ByteIn = 8'h55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("done_ignores_bytes", {30'b0, ByteReady, Done}, 32'd1);
        @(posedge clk);
        #1;
        ByteValid = 1'b0;

        // Zero length
        base = we_cnt;
        run_load(0, 1'b0, 1'b0);
        chk("zero_no_we", 32'(we_cnt), 32'(base));

        // Oversize length, then recover with a one-word load
        run_load(DEPTH + 1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("over_no_we", 32'(we_cnt), 32'(base));
        run_load(1, 1'b0, 1'b1);
        chk("recover_one_write", 32'(we_cnt), 32'(base + 1));

        // Random gaps on ByteValid
        for (int n = 0; n < 4; n++)
            run_load($urandom_range(1, 20), 1'b1, n[0]);

        // Full capacity
        base = we_cnt;
        run_load(DEPTH, 1'b0, 1'b0);
        chk("full_count", 32'(we_cnt - base), DEPTH);
        chk("full_last_addr", last_addr, (DEPTH - 1) * 4);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
